// File: rtl/sort_sequencer_if.sv
// Load and stream handshake bundle for sort_sequencer.
// The DUT takes the slave view; the producer/consumer side takes the master view.
interface sort_sequencer_if #(
    parameter int unsigned W = 4
);
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic         out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/sort_sequencer.sv
// Batch bubble sorter: loads N values, sorts with one shared compare-and-swap per clock,
// then streams the batch out smallest first.
module sort_sequencer #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 4
) (
    input  logic            clk,
    input  logic            rst,
    sort_sequencer_if.slave bus,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [7:0]      swap_count
);
    localparam int unsigned PW = $clog2(N);
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, SORT, OUT} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  mem [N];
    logic [CW-1:0] count, count_nxt;
    logic [PW-1:0] rd_ptr, rd_ptr_inc;
    logic [PW-1:0] pass, j, j1, j_last;
    logic [W-1:0]  a, b;
    logic          gt;
    logic          load_ok, start_ok, pass_end, sort_end, xfer, last_xfer;

    // Shared comparator datapath: a = mem[j], b = mem[j+1]; only gt causes a swap
    assign j1         = j + PW'(1);
    assign j_last     = PW'(N - 2) - pass;
    assign rd_ptr_inc = rd_ptr + PW'(1);
    assign a          = mem[j];
    assign b          = mem[j1];
    assign gt         = (a > b);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and per-cycle control decode
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        load_ok   = 1'b0;
        start_ok  = 1'b0;
        pass_end  = 1'b0;
        sort_end  = 1'b0;
        xfer      = 1'b0;
        last_xfer = 1'b0;
        case (state)
            IDLE: begin
                load_ok  = bus.in_valid && (count < CW'(N));
                start_ok = start && (count == CW'(N));
                if (load_ok)  count_nxt = count + CW'(1);
                if (start_ok) state_nxt = SORT;
            end
            SORT: begin
                pass_end = (j == j_last);
                sort_end = pass_end && (pass == PW'(N - 2));
                if (sort_end) state_nxt = OUT;
            end
            OUT: begin
                xfer      = bus.out_ready;
                last_xfer = xfer && (rd_ptr == PW'(N - 1));
                if (last_xfer) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Entry storage: loads in IDLE, compare-and-swap in SORT; contents not reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (load_ok) mem[PW'(count)] <= bus.in_data;
            if ((state == SORT) && gt) begin
                mem[j]  <= b;
                mem[j1] <= a;
            end
        end
    end

    // Counters, sweep indices and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            rd_ptr       <= '0;
            pass         <= '0;
            j            <= '0;
            swap_count   <= '0;
            done         <= 1'b0;
            busy         <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            count        <= count_nxt;
            done         <= last_xfer;
            busy         <= (state_nxt != IDLE);
            bus.in_ready <= (state_nxt == IDLE) && (count_nxt < CW'(N));

            if (start_ok) begin
                swap_count <= '0;
                pass       <= '0;
                j          <= '0;
            end

            if (state == SORT) begin
                if (gt) swap_count <= swap_count + 8'd1;
                if (pass_end) begin
                    j    <= '0;
                    pass <= pass + PW'(1);
                end else begin
                    j <= j1;
                end
            end

            // Final compare is always at j = 0, so the new mem[0] is min(a, b)
            if (sort_end) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= gt ? b : a;
                bus.out_last  <= 1'b0;
            end

            if (xfer) begin
                if (last_xfer) begin
                    rd_ptr        <= '0;
                    bus.out_valid <= 1'b0;
                    bus.out_data  <= '0;
                    bus.out_last  <= 1'b0;
                end else begin
                    rd_ptr       <= rd_ptr_inc;
                    bus.out_data <= mem[rd_ptr_inc];
                    bus.out_last <= (rd_ptr_inc == PW'(N - 1));
                end
            end
        end
    end
endmodule
